// File: rtl/psc_trigger_pkg.sv
// Shared definitions for the PSC trigger link.
// The receive parser and the transmit-side byte ROM both use these:
// K-character framing constants, the trigger command value, the
// payload geometry, the receive state encoding and the abort cause codes.
package psc_trigger_pkg;

    localparam logic [7:0] SOP      = 8'b001_11100;  // K28.1
    localparam logic [7:0] EOP      = 8'b101_11100;  // K28.5
    localparam logic [7:0] TRIG_CMD = 8'h30;

    localparam int PAYLOAD_LEN = 8;
    localparam int TIMEOUT     = 64;

    localparam int IDX_W = $clog2(PAYLOAD_LEN);
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    localparam logic [IDX_W-1:0] IDX_CMD  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAYLOAD_LEN - 1);
    // The abort is decided on the TIMEOUT-th empty cycle, i.e. when the
    // counter already holds TIMEOUT-1 and another empty cycle arrives.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_PAYLOAD    = 2'd1,
        ST_EXPECT_EOP = 2'd2
    } rx_state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_CODE    = 2'd1,
        ERR_FORMAT  = 2'd2,
        ERR_TIMEOUT = 2'd3
    } err_code_t;

    // True when the decoded byte is the given K character.
    function automatic logic k_match(input logic is_k,
                                     input logic [7:0] data,
                                     input logic [7:0] ch);
        return is_k && (data == ch);
    endfunction

endpackage

// File: rtl/psc_sat_counter.sv
// Saturating up-counter for host-visible statistics.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   inc        : increment request for this cycle
//   count      : current value; sticks at all-ones instead of wrapping
module psc_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/psc_trigger_rx_parser.sv
// Receive-side parser for the PSC trigger link.
// Frames SOP / 8 payload bytes / EOP packets from the 8b/10b decoder
// output, checks the fixed payload layout and reports results.
// Ports:
//   clk, rst_n   : clock and asynchronous active-low reset
//   rx_valid     : a decoded byte is presented this cycle
//   rx_data      : decoded byte
//   rx_is_k      : byte is a K character
//   rx_code_err  : decoder flagged a disparity/code violation
//   trigger      : one-cycle pulse on a completed trigger packet
//   pkt_done     : one-cycle pulse on any completed valid packet
//   pkt_err      : one-cycle pulse on a packet abort
//   err_code     : cause of the last abort (1 code/K, 2 format, 3 timeout)
//   last_cmd     : command byte of the last valid packet
//   pkt_count    : saturating count of valid packets
//   err_count    : saturating count of aborted packets
module psc_trigger_rx_parser
    import psc_trigger_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic        rx_is_k,
    input  logic        rx_code_err,
    output logic        trigger,
    output logic        pkt_done,
    output logic        pkt_err,
    output logic [1:0]  err_code,
    output logic [7:0]  last_cmd,
    output logic [15:0] pkt_count,
    output logic [15:0] err_count
);

    rx_state_t        state;
    logic [IDX_W-1:0] idx;
    logic [TMO_W-1:0] tmo_cnt;
    logic [7:0]       pending_cmd;
    err_code_t        err_code_q;

    logic      is_sop;
    logic      is_eop;
    logic      ev_abort;
    logic      ev_resync;
    logic      ev_done;
    err_code_t ev_code;

    assign is_sop   = k_match(rx_is_k, rx_data, SOP);
    assign is_eop   = k_match(rx_is_k, rx_data, EOP);
    assign err_code = err_code_q;

    // Decide this cycle's packet outcome. The events are combinational so
    // the statistics counters update on the same edge as the pulses.
    // A code-errored SOP is treated as a plain code error, not a resync.
    always_comb begin
        ev_abort  = 1'b0;
        ev_resync = 1'b0;
        ev_done   = 1'b0;
        ev_code   = ERR_NONE;
        case (state)
            ST_PAYLOAD: begin
                if (rx_valid) begin
                    if (rx_code_err) begin
                        ev_abort = 1'b1;
                        ev_code  = ERR_CODE;
                    end else if (rx_is_k) begin
                        ev_abort  = 1'b1;
                        ev_code   = ERR_CODE;
                        ev_resync = is_sop;
                    end else if (idx == IDX_CMD) begin
                        if ((rx_data != TRIG_CMD) && (rx_data != 8'h00)) begin
                            ev_abort = 1'b1;
                            ev_code  = ERR_FORMAT;
                        end
                    end else if (rx_data != 8'h00) begin
                        ev_abort = 1'b1;
                        ev_code  = ERR_FORMAT;
                    end
                end else if (tmo_cnt == TMO_LAST) begin
                    ev_abort = 1'b1;
                    ev_code  = ERR_TIMEOUT;
                end
            end
            ST_EXPECT_EOP: begin
                if (rx_valid) begin
                    if (rx_code_err) begin
                        ev_abort = 1'b1;
                        ev_code  = ERR_CODE;
                    end else if (is_eop) begin
                        ev_done = 1'b1;
                    end else if (rx_is_k) begin
                        ev_abort  = 1'b1;
                        ev_code   = ERR_CODE;
                        ev_resync = is_sop;
                    end else begin
                        ev_abort = 1'b1;
                        ev_code  = ERR_FORMAT;
                    end
                end else if (tmo_cnt == TMO_LAST) begin
                    ev_abort = 1'b1;
                    ev_code  = ERR_TIMEOUT;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            idx         <= '0;
            tmo_cnt     <= '0;
            pending_cmd <= '0;
            trigger     <= 1'b0;
            pkt_done    <= 1'b0;
            pkt_err     <= 1'b0;
            err_code_q  <= ERR_NONE;
            last_cmd    <= '0;
        end else begin
            trigger  <= 1'b0;
            pkt_done <= 1'b0;
            pkt_err  <= 1'b0;

            if (ev_abort) begin
                pkt_err    <= 1'b1;
                err_code_q <= ev_code;
            end

            if (ev_done) begin
                pkt_done <= 1'b1;
                last_cmd <= pending_cmd;
                trigger  <= (pending_cmd == TRIG_CMD);
            end

            if (ev_abort) begin
                // A SOP inside a packet both aborts the old one and opens
                // a new one, so the stream resynchronises without a gap.
                idx     <= '0;
                tmo_cnt <= '0;
                state   <= ev_resync ? ST_PAYLOAD : ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (rx_valid && is_sop && !rx_code_err) begin
                            state   <= ST_PAYLOAD;
                            idx     <= '0;
                            tmo_cnt <= '0;
                        end
                    end
                    ST_PAYLOAD: begin
                        if (rx_valid) begin
                            tmo_cnt <= '0;
                            if (idx == IDX_CMD) begin
                                pending_cmd <= rx_data;
                            end
                            if (idx == IDX_LAST) begin
                                state <= ST_EXPECT_EOP;
                            end else begin
                                idx <= idx + IDX_W'(1);
                            end
                        end else begin
                            tmo_cnt <= tmo_cnt + TMO_W'(1);
                        end
                    end
                    ST_EXPECT_EOP: begin
                        if (ev_done) begin
                            state <= ST_IDLE;
                        end else if (!rx_valid) begin
                            tmo_cnt <= tmo_cnt + TMO_W'(1);
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    psc_sat_counter #(.WIDTH(16)) u_pkt_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (ev_done),
        .count (pkt_count)
    );

    psc_sat_counter #(.WIDTH(16)) u_err_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (ev_abort),
        .count (err_count)
    );

endmodule

// File: tb/tb_psc_trigger_rx_parser.sv
// Directed bench for psc_trigger_rx_parser. Inputs are driven on the
// falling edge and outputs sampled on the falling edge, half a cycle
// after the rising edge that updates them.
module tb_psc_trigger_rx_parser;

    localparam logic [7:0] K_SOP = 8'h3C;
    localparam logic [7:0] K_EOP = 8'hBC;

    logic        clk;
    logic        rst_n;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_is_k;
    logic        rx_code_err;
    logic        trigger;
    logic        pkt_done;
    logic        pkt_err;
    logic [1:0]  err_code;
    logic [7:0]  last_cmd;
    logic [15:0] pkt_count;
    logic [15:0] err_count;

    int checks = 0;
    int errors = 0;

    psc_trigger_rx_parser dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .rx_is_k     (rx_is_k),
        .rx_code_err (rx_code_err),
        .trigger     (trigger),
        .pkt_done    (pkt_done),
        .pkt_err     (pkt_err),
        .err_code    (err_code),
        .last_cmd    (last_cmd),
        .pkt_count   (pkt_count),
        .err_count   (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic is_k, input logic [7:0] data,
                                 input logic code_err);
        @(negedge clk);
        rx_valid    = 1'b1;
        rx_is_k     = is_k;
        rx_data     = data;
        rx_code_err = code_err;
    endtask

    task automatic idleCycle();
        @(negedge clk);
        rx_valid    = 1'b0;
        rx_is_k     = 1'b0;
        rx_data     = 8'h00;
        rx_code_err = 1'b0;
    endtask

    task automatic sendPacket(input logic [7:0] cmd);
        applyStimulus(1'b1, K_SOP, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        applyStimulus(1'b0, cmd, 1'b0);
        repeat (6) applyStimulus(1'b0, 8'h00, 1'b0);
        applyStimulus(1'b1, K_EOP, 1'b0);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_trigger"},   32'(trigger),   32'd0);
        checkOutput({tag, "_pkt_done"},  32'(pkt_done),  32'd0);
        checkOutput({tag, "_pkt_err"},   32'(pkt_err),   32'd0);
        checkOutput({tag, "_err_code"},  32'(err_code),  32'd0);
        checkOutput({tag, "_last_cmd"},  32'(last_cmd),  32'd0);
        checkOutput({tag, "_pkt_count"}, 32'(pkt_count), 32'd0);
        checkOutput({tag, "_err_count"}, 32'(err_count), 32'd0);
    endtask

    // Pulse invariants, checked whenever a pulse is visible.
    always @(negedge clk) begin
        if (trigger || pkt_err) begin
            checkOutput("trig_and_err_exclusive", 32'(trigger & pkt_err), 32'd0);
            if (trigger) checkOutput("trig_implies_done", 32'(pkt_done), 32'd1);
        end
    end

    initial begin
        rst_n       = 1'b0;
        rx_valid    = 1'b0;
        rx_is_k     = 1'b0;
        rx_data     = 8'h00;
        rx_code_err = 1'b0;
        repeat (3) @(negedge clk);
        checkAllZero("reset");
        rst_n = 1'b1;

        // Trigger packet with rx_valid held high throughout
        sendPacket(8'h30);
        idleCycle();
        checkOutput("t1_trigger",   32'(trigger),   32'd1);
        checkOutput("t1_pkt_done",  32'(pkt_done),  32'd1);
        checkOutput("t1_pkt_err",   32'(pkt_err),   32'd0);
        checkOutput("t1_last_cmd",  32'(last_cmd),  32'h30);
        checkOutput("t1_pkt_count", 32'(pkt_count), 32'd1);
        idleCycle();
        checkOutput("t1_trigger_width",  32'(trigger),  32'd0);
        checkOutput("t1_pkt_done_width", 32'(pkt_done), 32'd0);

        // Null packet
        sendPacket(8'h00);
        idleCycle();
        checkOutput("null_pkt_done",  32'(pkt_done),  32'd1);
        checkOutput("null_trigger",   32'(trigger),   32'd0);
        checkOutput("null_last_cmd",  32'(last_cmd),  32'h00);
        checkOutput("null_pkt_count", 32'(pkt_count), 32'd2);

        // Back-to-back: trigger packet, SOP of a null packet on the next cycle
        sendPacket(8'h30);
        applyStimulus(1'b1, K_SOP, 1'b0);
        checkOutput("b2b_trigger",   32'(trigger),   32'd1);
        checkOutput("b2b_pkt_count", 32'(pkt_count), 32'd3);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("b2b_trigger_width", 32'(trigger), 32'd0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        repeat (6) applyStimulus(1'b0, 8'h00, 1'b0);
        applyStimulus(1'b1, K_EOP, 1'b0);
        idleCycle();
        checkOutput("b2b2_pkt_done",  32'(pkt_done),  32'd1);
        checkOutput("b2b2_trigger",   32'(trigger),   32'd0);
        checkOutput("b2b2_last_cmd",  32'(last_cmd),  32'h00);
        checkOutput("b2b2_pkt_count", 32'(pkt_count), 32'd4);

        // Format error: 0x55 at payload index 4
        applyStimulus(1'b1, K_SOP, 1'b0);
        repeat (4) applyStimulus(1'b0, 8'h00, 1'b0);
        applyStimulus(1'b0, 8'h55, 1'b0);
        idleCycle();
        checkOutput("fmt_pkt_err",   32'(pkt_err),   32'd1);
        checkOutput("fmt_err_code",  32'(err_code),  32'd2);
        checkOutput("fmt_err_count", 32'(err_count), 32'd1);
        checkOutput("fmt_pkt_count", 32'(pkt_count), 32'd4);
        idleCycle();
        checkOutput("fmt_pkt_err_width", 32'(pkt_err),  32'd0);
        checkOutput("fmt_err_code_held", 32'(err_code), 32'd2);
        sendPacket(8'h30);
        idleCycle();
        checkOutput("fmt_next_trigger",   32'(trigger),   32'd1);
        checkOutput("fmt_next_pkt_count", 32'(pkt_count), 32'd5);

        // Resync: SOP 00 30, then SOP and a full trigger packet
        applyStimulus(1'b1, K_SOP, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        applyStimulus(1'b0, 8'h30, 1'b0);
        applyStimulus(1'b1, K_SOP, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("rsy_pkt_err",   32'(pkt_err),   32'd1);
        checkOutput("rsy_err_code",  32'(err_code),  32'd1);
        checkOutput("rsy_err_count", 32'(err_count), 32'd2);
        applyStimulus(1'b0, 8'h30, 1'b0);
        checkOutput("rsy_pkt_err_width", 32'(pkt_err), 32'd0);
        repeat (6) applyStimulus(1'b0, 8'h00, 1'b0);
        applyStimulus(1'b1, K_EOP, 1'b0);
        idleCycle();
        checkOutput("rsy_trigger",   32'(trigger),   32'd1);
        checkOutput("rsy_pkt_count", 32'(pkt_count), 32'd6);
        checkOutput("rsy_err_count_final", 32'(err_count), 32'd2);

        // Timeout: last valid byte, then 64 empty cycles
        applyStimulus(1'b1, K_SOP, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        repeat (64) idleCycle();
        checkOutput("tmo_not_early", 32'(pkt_err), 32'd0);
        idleCycle();
        checkOutput("tmo_pkt_err",   32'(pkt_err),   32'd1);
        checkOutput("tmo_err_code",  32'(err_code),  32'd3);
        checkOutput("tmo_err_count", 32'(err_count), 32'd3);

        // Code error byte while idle is ignored
        applyStimulus(1'b0, 8'h12, 1'b1);
        idleCycle();
        idleCycle();
        checkOutput("idle_cerr_pkt_err",   32'(pkt_err),   32'd0);
        checkOutput("idle_cerr_err_count", 32'(err_count), 32'd3);
        checkOutput("idle_cerr_pkt_count", 32'(pkt_count), 32'd6);

        // Data byte where EOP is expected
        applyStimulus(1'b1, K_SOP, 1'b0);
        repeat (8) applyStimulus(1'b0, 8'h00, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        idleCycle();
        checkOutput("noeop_pkt_err",   32'(pkt_err),   32'd1);
        checkOutput("noeop_err_code",  32'(err_code),  32'd2);
        checkOutput("noeop_err_count", 32'(err_count), 32'd4);
        checkOutput("noeop_pkt_done",  32'(pkt_done),  32'd0);

        // Early EOP inside the payload
        applyStimulus(1'b1, K_SOP, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        applyStimulus(1'b1, K_EOP, 1'b0);
        idleCycle();
        checkOutput("early_k_pkt_err",   32'(pkt_err),   32'd1);
        checkOutput("early_k_err_code",  32'(err_code),  32'd1);
        checkOutput("early_k_err_count", 32'(err_count), 32'd5);
        checkOutput("early_k_pkt_done",  32'(pkt_done),  32'd0);

        // Reset in the middle of a packet
        applyStimulus(1'b1, K_SOP, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        applyStimulus(1'b0, 8'h30, 1'b0);
        @(negedge clk);
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        #1;
        checkAllZero("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        idleCycle();
        idleCycle();
        checkOutput("post_reset_pkt_err", 32'(pkt_err), 32'd0);
        checkOutput("post_reset_trigger", 32'(trigger), 32'd0);

        // Saturation of pkt_count
        force dut.u_pkt_counter.count = 16'hFFFE;
        @(negedge clk);
        release dut.u_pkt_counter.count;
        sendPacket(8'h30);
        idleCycle();
        checkOutput("sat_reach_pkt_count", 32'(pkt_count), 32'hFFFF);
        checkOutput("sat_reach_trigger",   32'(trigger),   32'd1);
        sendPacket(8'h00);
        idleCycle();
        checkOutput("sat_hold_pkt_count", 32'(pkt_count), 32'hFFFF);
        checkOutput("sat_hold_pkt_done",  32'(pkt_done),  32'd1);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
